// File: rtl/tdm_demux8.sv
// Receive side of an 8-slot TDM link. Each valid sample goes into a shadow slot chosen by
// the slot index, and all eight slots are published in parallel when slot 7 arrives.
module tdm_demux8 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [8*WIDTH-1:0] dout,
  output logic               frame_valid,
  output logic [2:0]         s,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [2:0]         s_q, s_d;
  logic [WIDTH-1:0]   shadow_q [7];
  logic [WIDTH-1:0]   shadow_d [7];
  logic [8*WIDTH-1:0] dout_q, dout_d, frame_w;
  logic               fv_q, fv_d, err_q, err_d;
  logic               wr_en;
  logic [2:0]         wr_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      s_q     <= 3'd0;
      dout_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 7; i++) shadow_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    if (din_valid) begin
      if (frame_sync) begin
        state_d = LOCKED;
        s_d     = 3'd1;
      end else if (state_q == LOCKED) begin
        if (s_q == 3'd0) begin
          state_d = HUNT;
          s_d     = 3'd0;
        end else begin
          s_d = s_q + 3'd1;  // 7 wraps to 0 on frame completion
        end
      end
    end
  end

  // A sync sample always lands in slot 0; it is only an error when it cuts a frame short.
  always_comb begin
    wr_en   = 1'b0;
    wr_slot = s_q;
    dout_d  = dout_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        wr_en   = 1'b1;
        wr_slot = 3'd0;
        err_d   = (state_q == LOCKED) && (s_q != 3'd0);
      end else if (state_q == LOCKED) begin
        if (s_q == 3'd0) begin
          err_d = 1'b1;
        end else if (s_q == 3'd7) begin
          dout_d = frame_w;
          fv_d   = 1'b1;
        end else begin
          wr_en = 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_slot
      assign shadow_d[gi] = (wr_en && wr_slot == 3'(gi)) ? din : shadow_q[gi];
      assign frame_w[gi*WIDTH +: WIDTH] = shadow_q[gi];
    end
  endgenerate
  assign frame_w[7*WIDTH +: WIDTH] = din;

  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign s           = s_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8 (WIDTH=1): a vector table of per-cycle stimulus/expectations
// plus a hand-written asynchronous reset sequence.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:0] din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] dout;
  logic       frame_valid;
  logic [2:0] s;
  logic       locked;
  logic       sync_err;

  int n_checks = 0;
  int n_pass   = 0;

  tdm_demux8 #(.WIDTH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .frame_valid(frame_valid),
    .s          (s),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       fs;
    logic       d;
    logic [7:0] e_dout;
    logic       e_fv;
    logic [2:0] e_s;
    logic       e_lk;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic fs, input logic d, input logic [7:0] e_dout,
                     input logic e_fv, input logic [2:0] e_s, input logic e_lk, input logic e_err);
    vec_t r;
    r.v = v; r.fs = fs; r.d = d; r.e_dout = e_dout;
    r.e_fv = e_fv; r.e_s = e_s; r.e_lk = e_lk; r.e_err = e_err;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_dout, input logic e_fv,
                         input logic [2:0] e_s, input logic e_lk, input logic e_err);
    chk({tag, ".dout"}, dout, e_dout);
    chk({tag, ".frame_valid"}, {7'd0, frame_valid}, {7'd0, e_fv});
    chk({tag, ".s"}, {5'd0, s}, {5'd0, e_s});
    chk({tag, ".locked"}, {7'd0, locked}, {7'd0, e_lk});
    chk({tag, ".sync_err"}, {7'd0, sync_err}, {7'd0, e_err});
  endtask

  // One accepted-or-idle cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic fs, input logic d);
    @(negedge clk);
    din_valid = v; frame_sync = fs; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] bits);
    for (int k = 0; k < 8; k++) step(1'b1, (k == 0), bits[k]);
  endtask

  initial begin
    // Frame 1: din 1,0,1,1,0,0,1,0 with sync on the first sample -> 8'h4D
    add(1,1,1, 8'h00,0,3'd1,1,0);
    add(1,0,0, 8'h00,0,3'd2,1,0);
    add(1,0,1, 8'h00,0,3'd3,1,0);
    add(1,0,1, 8'h00,0,3'd4,1,0);
    add(1,0,0, 8'h00,0,3'd5,1,0);
    add(1,0,0, 8'h00,0,3'd6,1,0);
    add(1,0,1, 8'h00,0,3'd7,1,0);
    add(1,0,0, 8'h4D,1,3'd0,1,0);
    add(0,0,0, 8'h4D,0,3'd0,1,0);
    // Sample at slot 0 without sync: sync lost
    add(1,0,1, 8'h4D,0,3'd0,0,1);
    add(0,0,0, 8'h4D,0,3'd0,0,0);
    // Hunting: unsynced samples discarded, sync without valid ignored
    for (int i = 0; i < 5; i++) add(1,0,1, 8'h4D,0,3'd0,0,0);
    add(0,1,1, 8'h4D,0,3'd0,0,0);
    // Back-to-back: frame 0,1,1,0,1,0,0,1 (8'h96) then all ones
    add(1,1,0, 8'h4D,0,3'd1,1,0);
    add(1,0,1, 8'h4D,0,3'd2,1,0);
    add(1,0,1, 8'h4D,0,3'd3,1,0);
    add(1,0,0, 8'h4D,0,3'd4,1,0);
    add(1,0,1, 8'h4D,0,3'd5,1,0);
    add(1,0,0, 8'h4D,0,3'd6,1,0);
    add(1,0,0, 8'h4D,0,3'd7,1,0);
    add(1,0,1, 8'h96,1,3'd0,1,0);
    add(1,1,1, 8'h96,0,3'd1,1,0);
    for (int i = 2; i < 8; i++) add(1,0,1, 8'h96,0,3'(i),1,0);
    add(1,0,1, 8'hFF,1,3'd0,1,0);
    // Gap of 3 idle cycles between slots 3 and 4: same 8'h4D
    add(1,1,1, 8'hFF,0,3'd1,1,0);
    add(1,0,0, 8'hFF,0,3'd2,1,0);
    add(1,0,1, 8'hFF,0,3'd3,1,0);
    add(1,0,1, 8'hFF,0,3'd4,1,0);
    for (int i = 0; i < 3; i++) add(0,0,0, 8'hFF,0,3'd4,1,0);
    add(1,0,0, 8'hFF,0,3'd5,1,0);
    add(1,0,0, 8'hFF,0,3'd6,1,0);
    add(1,0,1, 8'hFF,0,3'd7,1,0);
    add(1,0,0, 8'h4D,1,3'd0,1,0);
    // Early sync at slot 4; resync sample becomes slot 0 of the next frame (8'h7F)
    add(1,1,0, 8'h4D,0,3'd1,1,0);
    add(1,0,0, 8'h4D,0,3'd2,1,0);
    add(1,0,0, 8'h4D,0,3'd3,1,0);
    add(1,0,0, 8'h4D,0,3'd4,1,0);
    add(1,1,1, 8'h4D,0,3'd1,1,1);
    for (int i = 2; i < 8; i++) add(1,0,1, 8'h4D,0,3'(i),1,0);
    add(1,0,0, 8'h7F,1,3'd0,1,0);
    // Early sync at slot 7 discards the partial frame
    add(1,1,1, 8'h7F,0,3'd1,1,0);
    for (int i = 2; i < 8; i++) add(1,0,0, 8'h7F,0,3'(i),1,0);
    add(1,1,0, 8'h7F,0,3'd1,1,1);
    for (int i = 2; i < 8; i++) add(1,0,0, 8'h7F,0,3'(i),1,0);
    add(1,0,1, 8'h80,1,3'd0,1,0);

    // Reset state
    #2;
    chk_all("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].fs, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_fv, vecs[i].e_s,
              vecs[i].e_lk, vecs[i].e_err);
    end

    // Asynchronous reset mid-frame at s=5
    for (int k = 0; k < 5; k++) step(1'b1, (k == 0), 1'b1);
    chk_all("pre_rst", 8'h80, 1'b0, 3'd5, 1'b1, 1'b0);
    @(negedge clk);
    din_valid = 1'b0; frame_sync = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk_all("post_rst", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk_all("post_rst_hunt", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    run_frame(8'h4D);
    chk_all("post_rst_frame", 8'h4D, 1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_all("post_rst_idle", 8'h4D, 1'b0, 3'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive-side counterpart of the 8:1 select mux: rebuilds an 8-slot time-division frame from a serialized sample stream.
- A transmitter sweeps the mux select 0..7 and drives one slot per valid cycle, with `frame_sync` marking slot 0.
- This block tracks the slot index, deposits each sample into a shadow register, and publishes all eight slots in parallel once slot 7 arrives.
- Sits directly downstream of the serializing mux; `dout` bit/field k corresponds to mux input k.

Parameters:
- WIDTH, 1, bits per slot sample (WIDTH=1 pairs with the 1-bit 8:1 mux).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  serialized slot sample.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the current sample as slot 0.
- dout  output  8*WIDTH  last complete frame; slot k at dout[k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse when dout is updated.
- s  output  3  slot index the next valid sample will be written to (mirrors the transmitter's mux select).
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Internal: state=HUNT, shadow=0.
  - Outputs: dout=0, frame_valid=0, s=0, locked=0, sync_err=0.
  - Reset asserted mid-frame discards the partial frame.
  - dout is not updated by reset release.
- Accepted sample: din_valid=1 at a rising edge. Cycles with din_valid=0 change nothing; frame_valid and sync_err return to 0.
- frame_sync with din_valid=0 is ignored.
- HUNT state:
  - Accepted sample with frame_sync=1: shadow slot 0 <= din, s <= 1, go to LOCKED.
  - Accepted sample with frame_sync=0: discarded, s stays 0, no error pulse.
- LOCKED state, accepted sample at slot s:
  - s==0, frame_sync=1: shadow slot 0 <= din, s <= 1.
  - s==0, frame_sync=0 (sync lost):
    - sync_err=1 for one cycle.
    - Sample discarded; state <= HUNT, s <= 0.
    - dout is retained.
  - s in 1..6, frame_sync=0: shadow slot s <= din, s <= s+1.
  - s in 1..6, frame_sync=1 (early sync, resync):
    - sync_err=1 for one cycle.
    - Partial frame abandoned; sample written to shadow slot 0, s <= 1, stay LOCKED.
    - dout is not updated.
  - s==7, frame_sync=0 (frame complete):
    - On the same edge, dout <= shadow slots 0..6 plus din in slot 7; frame_valid=1 for the following cycle.
    - s wraps to 0; stay LOCKED.
  - s==7, frame_sync=1: treated as early sync (same as the 1..6 case).
- Latency: dout and frame_valid are visible one cycle after the edge that accepts slot 7.
- Back-to-back frames with no idle cycles must produce a frame_valid pulse every 8 accepted samples.
- Gaps (din_valid=0) are allowed anywhere within a frame and do not affect framing.
- s is 3-bit, wraps 7->0, and changes only on accepted samples or on error/reset.
- locked = (state==LOCKED), registered.
- frame_valid and sync_err are never both 1 in the same cycle.
- dout holds its value between frames; it changes only on frame completion.

Test Plan:
- Reset, then 8 accepted samples din=1,0,1,1,0,0,1,0 with frame_sync on the first (WIDTH=1) -> one cycle after the 8th edge: dout=8'b01001101, frame_valid=1 for exactly one cycle, s=0, locked=1.
- Samples without frame_sync from reset, 5 cycles -> locked=0, s=0, dout=0, no pulses. Then a sync frame -> normal lock and dout update.
- Two back-to-back frames (16 consecutive valid cycles, sync on cycles 1 and 9), second frame all ones -> frame_valid pulses 8 cycles apart; final dout=8'hFF.
- Frame with din_valid low for 3 cycles between slots 3 and 4 -> same dout as the gap-free frame; frame_valid timing shifts by 3 cycles.
- Locked; frame_sync re-asserted at slot 4 -> sync_err pulse, s=1, previous dout unchanged. The next 7 samples complete a frame whose slot 0 is the resync sample.
- Locked; frame complete, then next valid sample without frame_sync -> sync_err pulse, locked=0, s=0, dout retained.
- rst_n driven low mid-frame (s=5) asynchronously -> all outputs 0 immediately, without waiting for a clock edge. After release, a fresh frame decodes correctly.
